// File: rtl/debounce_multi.sv
// Multi-channel button/switch debouncer: per-channel synchroniser, stability filter,
// press/release edge pulses and a saturating hold counter for long-press detection.
module debounce_multi #(
    parameter int                    CHANNELS     = 4,
    parameter int                    COUNT_SIZE   = 24,
    parameter logic [COUNT_SIZE-1:0] STABLE_LIMIT = 24'd59,
    parameter logic [COUNT_SIZE-1:0] LONG_LIMIT   = 24'd1000,
    parameter int                    SYNC_STAGES  = 2,
    parameter logic [CHANNELS-1:0]   INVERT_IN    = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] pressed,
    output logic [CHANNELS-1:0] released,
    output logic [CHANNELS-1:0] long_press,
    output logic [CHANNELS-1:0] long_pulse
);

    typedef enum logic {ST_STABLE, ST_CHANGING} state_t;

    // Inversion is applied ahead of the first flop so reset value 0 means "not pressed".
    logic [CHANNELS-1:0] sync_reg [SYNC_STAGES];
    logic [CHANNELS-1:0] s;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    sync_reg[gi] <= '0;
                end else if (gi == 0) begin
                    sync_reg[gi] <= in ^ INVERT_IN;
                end else begin
                    sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi - 1];
                end
            end
        end
    endgenerate

    assign s = sync_reg[SYNC_STAGES-1];

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            state_t                state_reg, state_next;
            logic [COUNT_SIZE-1:0] cnt_reg, cnt_next;
            logic [COUNT_SIZE-1:0] hold_reg, hold_next;
            logic                  out_reg, out_next;
            logic                  pressed_reg, released_reg;
            logic                  lp_reg, lp_next;
            logic                  lpulse_reg;

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    state_reg    <= ST_STABLE;
                    cnt_reg      <= '0;
                    hold_reg     <= '0;
                    out_reg      <= 1'b0;
                    pressed_reg  <= 1'b0;
                    released_reg <= 1'b0;
                    lp_reg       <= 1'b0;
                    lpulse_reg   <= 1'b0;
                end else begin
                    state_reg    <= state_next;
                    cnt_reg      <= cnt_next;
                    hold_reg     <= hold_next;
                    out_reg      <= out_next;
                    pressed_reg  <= out_next & ~out_reg;
                    released_reg <= ~out_next & out_reg;
                    lp_reg       <= lp_next;
                    lpulse_reg   <= lp_next & ~lp_reg;
                end
            end

            always_comb begin
                state_next = state_reg;
                cnt_next   = '0;
                out_next   = out_reg;
                case (state_reg)
                    ST_STABLE: begin
                        if (s[gi] != out_reg) begin
                            // A zero limit accepts the very first differing sample.
                            if (STABLE_LIMIT == '0) begin
                                out_next = ~out_reg;
                            end else begin
                                state_next = ST_CHANGING;
                                cnt_next   = COUNT_SIZE'(1);
                            end
                        end
                    end
                    ST_CHANGING: begin
                        if (s[gi] == out_reg) begin
                            state_next = ST_STABLE;
                        end else if (cnt_reg == STABLE_LIMIT) begin
                            out_next   = ~out_reg;
                            state_next = ST_STABLE;
                        end else begin
                            cnt_next = cnt_reg + COUNT_SIZE'(1);
                        end
                    end
                    default: begin
                        state_next = ST_STABLE;
                    end
                endcase
            end

            // Hold counter counts completed cycles with out high and saturates at the limit.
            always_comb begin
                hold_next = '0;
                lp_next   = 1'b0;
                if (out_next) begin
                    if (out_reg && (hold_reg != LONG_LIMIT)) begin
                        hold_next = hold_reg + COUNT_SIZE'(1);
                    end else begin
                        hold_next = hold_reg;
                    end
                    lp_next = (LONG_LIMIT != '0) && (hold_next == LONG_LIMIT);
                end
            end

            assign out[gi]        = out_reg;
            assign pressed[gi]    = pressed_reg;
            assign released[gi]   = released_reg;
            assign long_press[gi] = lp_reg;
            assign long_pulse[gi] = lpulse_reg;
        end
    endgenerate

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Parametrised, multi-channel successor to the single-input debouncer.
- Each channel takes a raw, asynchronous button or switch input, synchronises it, and filters bounce with a per-channel stability counter.
- Each channel drives a clean level, single-cycle press and release pulses, and a long-press indication.
- Sits between board pins and user logic: menu FSMs, LED controllers and similar.

Parameters:
CHANNELS, 4, number of independent inputs (1..32)
COUNT_SIZE, 24, width of the per-channel stability counter and hold counter
STABLE_LIMIT, 24'd59, number of extra consecutive differing samples required before a level change is accepted
LONG_LIMIT, 24'd1000, cycles the debounced level must stay 1 before long_press asserts; 0 disables long-press
SYNC_STAGES, 2, synchroniser flop depth (2..4)
INVERT_IN, 0, per-channel bit mask; a 1 inverts that raw input (for active-low buttons) before synchronisation

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset; 0 = in reset
in  in  CHANNELS  raw, asynchronous inputs
out  out  CHANNELS  debounced level per channel
pressed  out  CHANNELS  1-cycle pulse when out rises
released  out  CHANNELS  1-cycle pulse when out falls
long_press  out  CHANNELS  level; 1 while out has been 1 for at least LONG_LIMIT cycles
long_pulse  out  CHANNELS  1-cycle pulse on the cycle long_press first asserts

Behaviour:
- Reset: asynchronous assertion when reset=0; synchronous release on the first clock edge with reset=1.
- Reset values: all outputs 0; all counters 0; synchroniser flops 0, post-inversion, so no spurious edge occurs after release.
- Channels are fully independent; shared logic is parameters only.
- Synchroniser: (in ^ INVERT_IN) passes through SYNC_STAGES flops to give s[i].
- Stability FSM per channel, two states: STABLE and CHANGING.
  - STABLE: s == out; cnt = 0.
  - STABLE → CHANGING: when s != out, next cnt = 1.
  - CHANGING, s == out: return to STABLE, cnt cleared (bounce rejected).
  - CHANGING, s != out, cnt < STABLE_LIMIT: cnt increments.
  - CHANGING, s != out, cnt == STABLE_LIMIT: on this edge out toggles, cnt clears, return to STABLE.
- Acceptance rule: out changes on the (STABLE_LIMIT+1)th consecutive cycle with s != out.
- Latency from a clean step on in to out: SYNC_STAGES + STABLE_LIMIT + 1 clock edges.
- STABLE_LIMIT = 0 means out follows s with 1 cycle of delay.
- pressed/released are registered together with out. Each is high for exactly the one cycle in which out holds its new value, and never both in the same cycle.
- Hold counter per channel:
  - cleared while out = 0;
  - increments every cycle while out = 1;
  - saturates at LONG_LIMIT, never wraps.
- long_press: asserts on the cycle the hold counter reaches LONG_LIMIT; long_pulse is high that same single cycle.
- long_press deasserts in the same cycle out falls, i.e. together with released.
- A press shorter than LONG_LIMIT produces no long_pulse.
- LONG_LIMIT = 0: long_press and long_pulse are tied to 0.
- Counter width: STABLE_LIMIT and LONG_LIMIT must each be < 2^COUNT_SIZE. Compare for equality only; no overflow is possible by construction.
- Reset mid-operation: all state clears immediately. A held button after reset release is re-accepted through the full latency and produces a fresh pressed pulse.

Test Plan:
- Defaults, channel 0, in[0] steps 0→1 at a clock edge and is held: out[0] rises exactly 62 cycles later; pressed[0] is high for 1 cycle; released[0] stays 0.
- Bounce: in[0] toggles 7 times with 50–130 ns half-periods (clock 82 ns), then settles at 1; bounces shorter than 60 cycles never change out; exactly one pressed pulse follows final settling at +62 cycles.
- Glitch rejection: in[1] high for 59 sampled cycles, then low; out[1] stays 0 with no pulses. A 60-cycle high produces exactly one pressed and, after release, one released pulse.
- Long press: in[2] held 1200 cycles past acceptance; long_pulse[2] fires once at hold count 1000; long_press[2] stays high until out[2] falls, then clears together with released[2].
- Independence and inversion: INVERT_IN = 4'b1000, all in = 4'b1000 from reset; no output activity. Channel 0 pressing while channel 3 releases yields pulses only on those channels, at their own latencies.
- Reset mid-debounce: reset driven 0 with cnt = 30 on channel 0; all outputs 0 immediately. After release with in[0] still 1, out[0] rises 62 cycles later with one pressed pulse.
